matrix_operand_loader: RTL and testbench

Upstream feeder for `matrix_mult`. It accepts a serial stream of eight 32-bit elements over a valid/ready handshake and packs them into the 128-bit `A` and `B` operands. It then sequences the multiplier's `enable`/`done` protocol, holding operands stable and `enable` high until `done` returns, and reports completion or framing errors to the control side.

---
 rtl/matrix_operand_loader.sv | 150 +++++++++++++++
 tb/tb_matrix_operand_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Packs a serial stream of eight 32-bit elements into the 128-bit A/B
// operands of matrix_mult, then runs the enable/done handshake with it.
// Optional build macro: MATRIX_LOADER_TIMEOUT_EN adds a RUN-cycle watchdog
// that aborts a frame after TIMEOUT_CYCLES cycles without mult_done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accepting words 0..7 of a frame, in_ready high
// ST_SETUP | one cycle of stable operands before enable rises
// ST_RUN   | mult_enable high, waiting for mult_done (or timeout)
module matrix_operand_loader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic [127:0] mult_A,
  output logic [127:0] mult_B,
  output logic         mult_enable,
  input  logic         mult_done,
  output logic         busy,
  output logic         frame_done,
  output logic         frame_error
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] word_cnt;
  logic       accept;
  logic       word_is_last_slot;
  logic       last_ok;
  logic       last_bad;
  logic       run_done;
  logic       run_timeout;
  logic       ready_nx;
  logic       enable_nx;
  logic       busy_nx;
  logic       done_nx;
  logic       error_nx;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign accept            = (state == ST_LOAD) && in_valid && in_ready;
  assign word_is_last_slot = (word_cnt == 3'd7);
  assign last_ok           = accept && in_last && word_is_last_slot;
  assign last_bad          = accept && (in_last != word_is_last_slot);
  assign run_done          = (state == ST_RUN) && mult_done;

`ifdef MATRIX_LOADER_TIMEOUT_EN
  logic [7:0] run_cnt;

  // RUN-cycle counter; sits at zero outside RUN so it is clear on entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt <= 8'd0;
    end else if (state != ST_RUN) begin
      run_cnt <= 8'd0;
    end else begin
      run_cnt <= run_cnt + 8'd1;
    end
  end

  assign run_timeout = (state == ST_RUN) && !mult_done &&
                       (run_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign run_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (last_ok) state_nx = ST_SETUP;
      ST_SETUP: state_nx = ST_RUN;
      ST_RUN:   if (run_done || run_timeout) state_nx = ST_LOAD;
      default:  state_nx = ST_LOAD;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    ready_nx  = (state_nx == ST_LOAD);
    enable_nx = (state_nx == ST_RUN);
    busy_nx   = (state_nx != ST_LOAD);
    done_nx   = run_done;
    error_nx  = last_bad || run_timeout;
  end

  // Registered control outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      mult_enable <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      in_ready    <= ready_nx;
      mult_enable <= enable_nx;
      busy        <= busy_nx;
      frame_done  <= done_nx;
      frame_error <= error_nx;
    end
  end

  // Word counter; any in_last or slot 7 closes the frame, good or bad
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_cnt <= 3'd0;
    end else if (accept) begin
      word_cnt <= (in_last || word_is_last_slot) ? 3'd0 : word_cnt + 3'd1;
    end
  end

  // Operand slots; written only on accepted words, otherwise held
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_A <= '0;
      mult_B <= '0;
    end else if (accept) begin
      if (!word_cnt[2]) begin
        mult_A[{word_cnt[1:0], 5'd0} +: 32] <= in_data;
      end else begin
        mult_B[{word_cnt[1:0], 5'd0} +: 32] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Testbench for matrix_operand_loader: directed scenarios plus randomized
// frames, checked every cycle against a frame-level reference model.
module tb_matrix_operand_loader;

  localparam int TIMEOUT = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [127:0] mult_A;
  logic [127:0] mult_B;
  logic         mult_enable;
  logic         mult_done = 1'b0;
  logic         busy;
  logic         frame_done;
  logic         frame_error;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  int mult_lat = 4;
  bit mult_stall = 1'b0;

  // reference model state
  int           phase;
  logic [31:0]  fq[$];
  logic [127:0] e_a, e_b;
  bit           e_ready, e_en, e_busy, f_done, f_err;
  int           run_n;

  matrix_operand_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mult_A(mult_A), .mult_B(mult_B),
    .mult_enable(mult_enable), .mult_done(mult_done), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic m_reset();
    phase = 0; fq.delete(); e_a = '0; e_b = '0; run_n = 0;
    e_ready = 0; e_en = 0; e_busy = 0; f_done = 0; f_err = 0;
  endtask

  // One clock edge of the frame-level model: phase 0 collect, 1 setup, 2 run
  task automatic m_step();
    int pos;
    f_done = 0; f_err = 0;
    case (phase)
      0: if (e_ready && in_valid) begin
        pos = fq.size();
        fq.push_back(in_data);
        if (pos < 4) e_a[32*pos +: 32] = in_data;
        else         e_b[32*(pos-4) +: 32] = in_data;
        if (in_last != (pos == 7)) begin
          f_err = 1; fq.delete();
        end else if (pos == 7) begin
          phase = 1; fq.delete();
        end
      end
      1: begin phase = 2; run_n = 0; end
      default: begin
        if (mult_done) begin
          f_done = 1; phase = 0;
        end else begin
`ifdef MATRIX_LOADER_TIMEOUT_EN
          run_n++;
          if (run_n == TIMEOUT) begin f_err = 1; phase = 0; end
`endif
        end
      end
    endcase
    e_ready = (phase == 0);
    e_en    = (phase == 2);
    e_busy  = (phase != 0);
  endtask

  // Model update at each edge, full output comparison on the falling edge
  initial begin
    m_reset();
    forever begin
      @(posedge clock);
      if (!reset) m_reset(); else m_step();
      @(negedge clock);
      if (!reset) m_reset();
      chk("in_ready", in_ready, e_ready);
      chk("mult_enable", mult_enable, e_en);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, f_done);
      chk("frame_error", frame_error, f_err);
      chk("mult_A", mult_A, e_a);
      chk("mult_B", mult_B, e_b);
      chk("done_err_excl", frame_done & frame_error, 0);
      if (frame_done) done_pulses++;
      if (frame_error) err_pulses++;
    end
  end

  // Bench multiplier: done rises mult_lat edges after enable rose
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (!mult_enable) begin
        cnt = 0; mult_done = 1'b0;
      end else if (!mult_stall && cnt >= mult_lat) begin
        mult_done = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("ready_wait", 0, 1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input bit gapped);
    for (int k = 0; k < 8; k++) begin
      if (gapped && k > 0) idle(1);
      send_word(base + 32'(k), k == 7);
    end
  endtask

  // Called right after the 8th accept; returns number of enable-high cycles
  task automatic wait_frame_end(output int en_cycles);
    chk("setup_busy", busy, 1);
    chk("setup_ready", in_ready, 0);
    chk("setup_enable", mult_enable, 0);
    @(posedge clock); #1;
    chk("enable_rise", mult_enable, 1);
    en_cycles = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (!mult_enable) break;
      en_cycles++;
    end
  endtask

  initial begin
    int n, d0, e0, kind, cut;
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", mult_enable, 0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    @(negedge clock);
    chk("ready_before_edge", in_ready, 0);
    @(posedge clock); #1;
    chk("ready_after_release", in_ready, 1);

    // back-to-back frame 1..8
    d0 = done_pulses;
    send_frame(32'd1, 0);
    wait_frame_end(n);
    chk("enable_cycles", n, 5);
    chk("done_at_fall", frame_done, 1);
    chk("ready_at_done", in_ready, 1);
    chk("A_1to8", mult_A, 128'h00000004_00000003_00000002_00000001);
    chk("B_1to8", mult_B, 128'h00000008_00000007_00000006_00000005);
    chk("model_A_pin", e_a, 128'h00000004_00000003_00000002_00000001);
    idle(2);
    chk("done_once", done_pulses - d0, 1);

    // gapped frame
    send_frame(32'd1, 1);
    wait_frame_end(n);
    chk("gap_enable_cycles", n, 5);
    chk("gap_A", mult_A, 128'h00000004_00000003_00000002_00000001);
    chk("gap_B", mult_B, 128'h00000008_00000007_00000006_00000005);
    idle(1);

    // framing error on 3rd word, then a good frame 9..16
    e0 = err_pulses;
    send_word(32'd9, 0);
    send_word(32'd10, 0);
    send_word(32'd11, 1);
    chk("ferr_pulse", frame_error, 1);
    chk("ferr_ready", in_ready, 1);
    send_frame(32'd9, 0);
    wait_frame_end(n);
    chk("after_err_A0", mult_A[31:0], 32'd9);
    chk("after_err_B", mult_B, 128'h00000010_0000000f_0000000e_0000000d);
    idle(2);
    chk("ferr_once", err_pulses - e0, 1);

    // reset two cycles into RUN
    d0 = done_pulses;
    send_frame(32'd17, 0);
    @(posedge clock); #1;
    chk("midrun_enable", mult_enable, 1);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_enable", mult_enable, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", in_ready, 0);
    chk("async_A", mult_A, 0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    chk("no_done_after_rst", done_pulses - d0, 0);
    send_frame(32'd25, 0);
    wait_frame_end(n);
    chk("post_rst_cycles", n, 5);
    chk("post_rst_A", mult_A, 128'h0000001c_0000001b_0000001a_00000019);
    idle(1);

`ifdef MATRIX_LOADER_TIMEOUT_EN
    mult_stall = 1'b1;
    e0 = err_pulses;
    d0 = done_pulses;
    send_frame(32'd33, 0);
    wait_frame_end(n);
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_err", frame_error, 1);
    chk("timeout_ready", in_ready, 1);
    idle(2);
    chk("timeout_err_once", err_pulses - e0, 1);
    chk("timeout_no_done", done_pulses - d0, 0);
    mult_stall = 1'b0;
`endif

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      mult_lat = $urandom_range(0, 6);
      kind = $urandom_range(0, 3);
      cut = $urandom_range(0, 6);
      for (int k = 0; k < 8; k++) begin
        if (kind == 1) idle($urandom_range(0, 2));
        if (kind == 2 && k == cut) begin
          send_word($urandom, 1);
          break;
        end
        send_word($urandom, (kind == 3) ? 1'b0 : (k == 7));
      end
      if (kind < 2) begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clock); #1;
          if (!busy) break;
        end
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
